// File: rtl/interrupt_pkg.sv
// rtl/interrupt_pkg.sv - request kinds, vector addresses and arbiter state encoding
package interrupt_pkg;

  typedef enum logic [1:0] {
    KIND_RESET = 2'd0,
    KIND_NMI   = 2'd1,
    KIND_BRK   = 2'd2,
    KIND_IRQ   = 2'd3
  } req_kind_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OFFER = 2'd1,
    ST_GAP   = 2'd2
  } arb_state_t;

  localparam logic [15:0] VEC_RESET   = 16'hFFFC;
  localparam logic [15:0] VEC_NMI     = 16'hFFFA;
  localparam logic [15:0] VEC_IRQ_BRK = 16'hFFFE;

  function automatic logic [15:0] vector_of(input req_kind_t kind);
    case (kind)
      KIND_RESET: vector_of = VEC_RESET;
      KIND_NMI:   vector_of = VEC_NMI;
      default:    vector_of = VEC_IRQ_BRK;
    endcase
  endfunction

endpackage

// File: rtl/reset_debounce.sv
// rtl/reset_debounce.sv - qualifies a soft-reset level held low for RST_DEBOUNCE cycles
module reset_debounce #(
  parameter int unsigned RST_DEBOUNCE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic in_n,
  output logic qualified
);

  localparam logic [3:0] CNT_MAX  = 4'(RST_DEBOUNCE);
  localparam logic [3:0] CNT_LAST = 4'(RST_DEBOUNCE - 1);

  logic [3:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (in_n) begin
      count <= '0;
    end else if (count != CNT_MAX) begin
      count <= count + 4'd1;
    end
  end

  // Fires only on the edge the count reaches the limit; saturation keeps it from re-firing.
  assign qualified = !in_n && (count == CNT_LAST);

endmodule

// File: rtl/interrupt_arbiter.sv
// rtl/interrupt_arbiter.sv - latches RESET/NMI/BRK, samples IRQ, offers one request at a time
module interrupt_arbiter
  import interrupt_pkg::*;
#(
  parameter int unsigned RST_DEBOUNCE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        soft_reset_n,
  input  logic        vblank,
  input  logic        irq_n,
  input  logic        brk,
  input  logic        i_flag,
  input  logic        ack,
  output logic        req_valid,
  output logic [1:0]  req_kind,
  output logic [15:0] vector_addr,
  output logic [3:0]  pending
);

  arb_state_t  state, state_next;
  req_kind_t   kind_q, kind_next;
  logic [15:0] vec_q;
  logic        rst_lat, nmi_lat, brk_lat, vblank_prev;
  logic        soft_pulse, nmi_set, irq_live;
  logic        clr_rst, clr_nmi, clr_brk;

  reset_debounce #(
    .RST_DEBOUNCE(RST_DEBOUNCE)
  ) u_debounce (
    .clk       (clk),
    .rst       (rst),
    .in_n      (soft_reset_n),
    .qualified (soft_pulse)
  );

  assign nmi_set  = vblank && !vblank_prev;
  assign irq_live = !irq_n && !i_flag;

  always_comb begin
    state_next = state;
    kind_next  = kind_q;
    clr_rst    = 1'b0;
    clr_nmi    = 1'b0;
    clr_brk    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rst_lat || nmi_lat || brk_lat || irq_live) begin
          state_next = ST_OFFER;
          if (rst_lat)      kind_next = KIND_RESET;
          else if (nmi_lat) kind_next = KIND_NMI;
          else if (brk_lat) kind_next = KIND_BRK;
          else              kind_next = KIND_IRQ;
        end
      end
      ST_OFFER: begin
        if (ack) begin
          state_next = ST_GAP;
          clr_rst    = (kind_q == KIND_RESET);
          clr_nmi    = (kind_q == KIND_NMI);
          clr_brk    = (kind_q == KIND_BRK);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // A set event in the ack cycle outranks the clear of the same latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      kind_q      <= KIND_RESET;
      vec_q       <= VEC_RESET;
      rst_lat     <= 1'b0;
      nmi_lat     <= 1'b0;
      brk_lat     <= 1'b0;
      vblank_prev <= 1'b1;
    end else begin
      state       <= state_next;
      kind_q      <= kind_next;
      vec_q       <= vector_of(kind_next);
      rst_lat     <= soft_pulse || (rst_lat && !clr_rst);
      nmi_lat     <= nmi_set || (nmi_lat && !clr_nmi);
      brk_lat     <= brk || (brk_lat && !clr_brk);
      vblank_prev <= vblank;
    end
  end

  assign req_valid   = (state == ST_OFFER);
  assign req_kind    = kind_q;
  assign vector_addr = vec_q;
  assign pending     = {irq_live, brk_lat, nmi_lat, rst_lat};

endmodule

// File: tb/tb_interrupt_arbiter.sv
// tb/tb_interrupt_arbiter.sv - scripted vectors, corner sequences and randomized model check
module tb_interrupt_arbiter;

  localparam int DEB = 4;

  logic        clk = 1'b0;
  logic        rst, soft_reset_n, vblank, irq_n, brk, i_flag, ack;
  logic        req_valid;
  logic [1:0]  req_kind;
  logic [15:0] vector_addr;
  logic [3:0]  pending;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  interrupt_arbiter #(.RST_DEBOUNCE(DEB)) dut (
    .clk         (clk),
    .rst         (rst),
    .soft_reset_n(soft_reset_n),
    .vblank      (vblank),
    .irq_n       (irq_n),
    .brk         (brk),
    .i_flag      (i_flag),
    .ack         (ack),
    .req_valid   (req_valid),
    .req_kind    (req_kind),
    .vector_addr (vector_addr),
    .pending     (pending)
  );

  typedef struct {
    string      grp;
    logic       r, srn, vb, irqn, bk, ifl, ak;
    logic       ev;
    logic [1:0] ek;
    logic [3:0] ep;
  } vec_t;

  vec_t  tbl[$];
  string cur_grp;

  function automatic logic [15:0] spec_vector(input logic [1:0] k);
    if (k == 2'd0) return 16'hFFFC;
    if (k == 2'd1) return 16'hFFFA;
    return 16'hFFFE;
  endfunction

  task automatic add(input logic r, srn, vb, irqn, bk, ifl, ak, ev,
                     input logic [1:0] ek, input logic [3:0] ep);
    vec_t v;
    v.grp = cur_grp; v.r = r; v.srn = srn; v.vb = vb; v.irqn = irqn;
    v.bk = bk; v.ifl = ifl; v.ak = ak; v.ev = ev; v.ek = ek; v.ep = ep;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic r, srn, vb, irqn, bk, ifl, ak);
    rst = r; soft_reset_n = srn; vblank = vb; irq_n = irqn;
    brk = bk; i_flag = ifl; ack = ak;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic ev, input logic [1:0] ek,
                       input logic [3:0] ep, input logic chk_kv);
    logic bad;
    vectors++;
    bad = (req_valid !== ev) || (pending !== ep) ||
          (chk_kv && ((req_kind !== ek) || (vector_addr !== spec_vector(ek))));
    if (bad) begin
      miscompares++;
      $display("FAIL %s @%0t: got valid=%0b kind=%0d vec=%h pending=%b, required valid=%0b kind=%0d vec=%h pending=%b",
               name, $time, req_valid, req_kind, vector_addr, pending,
               ev, ek, spec_vector(ek), ep);
    end
  endtask

  // Reference model: pending events as a set, offers picked by lowest priority index.
  int       run_len;
  bit       m_prev;
  bit [2:0] lat;
  int       phase;
  int       mkind;

  task automatic model_reset();
    run_len = 0; m_prev = 1'b1; lat = '0; phase = 0; mkind = 0;
  endtask

  task automatic model_step(input bit r, srn, vb, irqn, bk, ifl, ak);
    bit       live;
    bit [2:0] sets;
    if (r) begin
      model_reset();
      return;
    end
    live = !irqn && !ifl;
    sets = '0;
    if (!srn) begin
      if (run_len < DEB) begin
        run_len++;
        if (run_len == DEB) sets[0] = 1'b1;
      end
    end else begin
      run_len = 0;
    end
    if (vb && !m_prev) sets[1] = 1'b1;
    if (bk) sets[2] = 1'b1;
    m_prev = vb;
    if (phase == 0) begin
      if (lat != 0 || live) begin
        phase = 1;
        mkind = 3;
        for (int p = 2; p >= 0; p--) if (lat[p]) mkind = p;
      end
    end else if (phase == 1) begin
      if (ak) begin
        phase = 2;
        if (mkind < 3) lat[mkind] = 1'b0;
      end
    end else begin
      phase = 0;
    end
    lat |= sets;
  endtask

  initial begin
    bit r_r, srn_r, vb_r, irqn_r, bk_r, ifl_r, ak_r;

    rst = 1'b1; soft_reset_n = 1'b1; vblank = 1'b0; irq_n = 1'b1;
    brk = 1'b0; i_flag = 1'b1; ack = 1'b0;

    cur_grp = "reset_state";
    add(1,1,0,1,0,1,0, 0,2'd0,4'b0000);

    cur_grp = "soft_reset_qualified";
    for (int i = 0; i < 3; i++) add(0,0,0,1,0,1,0, 0,2'd0,4'b0000);
    add(0,0,0,1,0,1,0, 0,2'd0,4'b0001);
    add(0,1,0,1,0,1,0, 1,2'd0,4'b0001);
    add(0,1,0,1,0,1,1, 0,2'd0,4'b0000);
    add(0,1,0,1,0,1,0, 0,2'd0,4'b0000);

    cur_grp = "soft_reset_short";
    for (int i = 0; i < 3; i++) add(0,0,0,1,0,1,0, 0,2'd0,4'b0000);
    for (int i = 0; i < 3; i++) add(0,1,0,1,0,1,0, 0,2'd0,4'b0000);

    cur_grp = "nmi_held_high";
    add(0,1,1,1,0,1,0, 0,2'd0,4'b0010);
    add(0,1,1,1,0,1,0, 1,2'd1,4'b0010);
    add(0,1,1,1,0,1,1, 0,2'd0,4'b0000);
    for (int i = 0; i < 17; i++) add(0,1,1,1,0,1,0, 0,2'd0,4'b0000);
    add(0,1,0,1,0,1,0, 0,2'd0,4'b0000);

    cur_grp = "nmi_then_brk";
    add(0,1,1,1,1,1,0, 0,2'd0,4'b0110);
    add(0,1,1,1,0,1,0, 1,2'd1,4'b0110);
    add(0,1,1,1,0,1,1, 0,2'd0,4'b0100);
    add(0,1,1,1,0,1,0, 0,2'd0,4'b0100);
    add(0,1,1,1,0,1,0, 1,2'd2,4'b0100);
    add(0,1,0,1,0,1,1, 0,2'd0,4'b0000);
    add(0,1,0,1,0,1,0, 0,2'd0,4'b0000);

    cur_grp = "irq_masking";
    add(0,1,0,0,0,1,0, 0,2'd0,4'b0000);
    add(0,1,0,0,0,1,0, 0,2'd0,4'b0000);
    add(0,1,0,0,0,0,0, 1,2'd3,4'b1000);
    add(0,1,0,0,0,1,0, 1,2'd3,4'b0000);
    add(0,1,0,1,0,1,0, 1,2'd3,4'b0000);
    add(0,1,0,1,0,1,1, 0,2'd0,4'b0000);
    add(0,1,0,1,0,1,0, 0,2'd0,4'b0000);

    cur_grp = "nmi_during_ack";
    add(0,1,1,1,0,1,0, 0,2'd0,4'b0010);
    add(0,1,1,1,0,1,0, 1,2'd1,4'b0010);
    add(0,1,0,1,0,1,0, 1,2'd1,4'b0010);
    add(0,1,1,1,0,1,1, 0,2'd0,4'b0010);
    add(0,1,1,1,0,1,0, 0,2'd0,4'b0010);
    add(0,1,1,1,0,1,0, 1,2'd1,4'b0010);
    add(0,1,1,1,0,1,1, 0,2'd0,4'b0000);
    add(0,1,0,1,0,1,0, 0,2'd0,4'b0000);

    cur_grp = "rst_mid_offer";
    add(0,1,1,1,0,1,0, 0,2'd0,4'b0010);
    add(0,1,1,1,0,1,0, 1,2'd1,4'b0010);
    add(1,0,1,1,1,1,0, 0,2'd0,4'b0000);
    for (int i = 0; i < 3; i++) add(0,1,1,1,0,1,0, 0,2'd0,4'b0000);
    add(0,1,0,1,0,1,0, 0,2'd0,4'b0000);

    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].srn, tbl[i].vb, tbl[i].irqn, tbl[i].bk, tbl[i].ifl, tbl[i].ak);
      check(tbl[i].grp, tbl[i].ev, tbl[i].ek, tbl[i].ep, tbl[i].ev || tbl[i].r);
    end

    // BRK arriving while IRQ is offered stays latched; stray ack in IDLE does nothing.
    drive(0,1,0,1,0,1,1); check("ack_in_idle", 1'b0, 2'd0, 4'b0000, 1'b0);
    drive(0,1,0,0,0,0,0); check("irq_offer", 1'b1, 2'd3, 4'b1000, 1'b1);
    drive(0,1,0,0,1,0,0); check("brk_behind_irq", 1'b1, 2'd3, 4'b1100, 1'b1);
    drive(0,1,0,0,0,0,1); check("irq_ack_keeps_brk", 1'b0, 2'd0, 4'b1100, 1'b0);
    drive(0,1,0,1,0,1,0); check("gap_to_idle", 1'b0, 2'd0, 4'b0100, 1'b0);
    drive(0,1,0,1,0,1,0); check("brk_offer", 1'b1, 2'd2, 4'b0100, 1'b1);
    drive(0,1,0,1,0,1,1); check("brk_ack", 1'b0, 2'd0, 4'b0000, 1'b0);
    drive(0,1,0,1,0,1,0); check("quiet", 1'b0, 2'd0, 4'b0000, 1'b0);

    drive(1,1,0,1,0,1,0);
    model_reset();
    check("random_reset", 1'b0, 2'd0, 4'b0000, 1'b1);
    srn_r = 1'b1; vb_r = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      r_r = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 19) == 0) srn_r = !srn_r;
      if ($urandom_range(0, 5) == 0)  vb_r = !vb_r;
      bk_r   = ($urandom_range(0, 9) == 0);
      irqn_r = ($urandom_range(0, 3) != 0);
      ifl_r  = 1'($urandom_range(0, 1));
      ak_r   = ($urandom_range(0, 2) == 0);
      drive(r_r, srn_r, vb_r, irqn_r, bk_r, ifl_r, ak_r);
      model_step(r_r, srn_r, vb_r, irqn_r, bk_r, ifl_r, ak_r);
      check("random", phase == 1, 2'(mkind), {!irqn_r && !ifl_r, lat},
            (phase == 1) || r_r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/interrupt_arbiter.md
INTERRUPT_ARBITER -- requirements
Module: interrupt_arbiter

Interface
REQ-001 SHALL have parameter RST_DEBOUNCE, default 4, the number of consecutive low cycles of soft_reset_n that qualifies a soft reset (range 1-15).
REQ-002 SHALL have port clk, input, 1, the single clock; all state on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port soft_reset_n, input, 1, active-low soft-reset level.
REQ-005 SHALL have port vblank, input, 1, PPU status bit 7 level; rising edge = NMI.
REQ-006 SHALL have port irq_n, input, 1, active-low maskable IRQ level.
REQ-007 SHALL have port brk, input, 1, one-cycle BRK pulse from the instruction engine.
REQ-008 SHALL have port i_flag, input, 1, CPU status bit 2 (interrupt disable).
REQ-009 SHALL have port ack, input, 1, handler acceptance of the offered request.
REQ-010 SHALL have port req_valid, output, 1, request offered to the interrupt handler.
REQ-011 SHALL have port req_kind, output, 2, 0=RESET, 1=NMI, 2=BRK, 3=IRQ.
REQ-012 SHALL have port vector_addr, output, 16, low-byte vector address: RESET 16'hFFFC, NMI 16'hFFFA, BRK/IRQ 16'hFFFE.
REQ-013 SHALL have port pending, output, 4, latch state {irq_live, brk, nmi, reset} as bits [3:0] = {IRQ, BRK, NMI, RESET}.

Function
REQ-014 SHALL count consecutive cycles with soft_reset_n=0, saturating at RST_DEBOUNCE; the reset latch sets on the cycle the count reaches RST_DEBOUNCE; count clears when soft_reset_n=1.
REQ-015 SHALL set the NMI latch at the edge where vblank=1 and the registered previous vblank=0; a held-high vblank sets it once only.
REQ-016 SHALL set the BRK latch at any edge where brk=1.
REQ-017 SHALL treat IRQ as unlatched: irq_live = !irq_n && !i_flag, evaluated every cycle.
REQ-018 SHALL use fixed priority RESET > NMI > BRK > IRQ.
REQ-019 SHALL implement states IDLE, OFFER, GAP; req_valid=1 only in OFFER.
REQ-020 IDLE -> OFFER at the edge where any of {reset latch, NMI latch, BRK latch, irq_live} is 1; req_kind/vector_addr registered from the highest-priority source at that edge.
REQ-021 Latency: a source latched at edge k yields req_valid=1 after edge k+1 (vblank rising sampled at edge k -> req_valid after edge k+1).
REQ-022 In OFFER, req_kind and vector_addr SHALL stay frozen until ack; no preemption, including by RESET; no withdrawal if i_flag sets or irq_n deasserts.
REQ-023 OFFER with ack=1 -> GAP; the latch matching req_kind clears at that edge (IRQ has no latch to clear).
REQ-024 A new set event for the same latch in the ack cycle SHALL win over the clear (latch stays 1).
REQ-025 GAP -> IDLE unconditionally; req_valid=0 for exactly one cycle between consecutive requests.
REQ-026 ack outside OFFER SHALL be ignored.
REQ-027 Latches not selected SHALL remain set while another request is offered.

Reset
REQ-028 On rst=1 at a clock edge: state IDLE, all latches 0, debounce count 0, previous-vblank register 1, req_valid 0, req_kind 0, vector_addr 16'hFFFC, pending 0.
REQ-029 rst mid-OFFER SHALL drop req_valid the next cycle and discard all pending events; vblank high across reset release SHALL NOT produce an NMI.

Structure
REQ-030 Shared package interrupt_pkg SHALL hold req_kind encodings, vector address constants and the state encoding.
REQ-031 The debounce counter SHALL be a sub-module named reset_debounce (ports clk, rst, in_n, qualified pulse).

Verification
REQ-032 soft_reset_n low 4 cycles (RST_DEBOUNCE=4) -> req_valid, req_kind=0, vector 16'hFFFC; low 3 cycles then high -> no request.
REQ-033 vblank rises at edge k, held high 20 cycles, ack at first OFFER cycle -> exactly one NMI request (vector 16'hFFFA) valid after edge k+1, then GAP.
REQ-034 brk pulse and vblank rise same edge -> NMI offered first; ack -> GAP one cycle -> BRK offered with vector 16'hFFFE; pending[2] held throughout.
REQ-035 irq_n=0 with i_flag=1 -> no request; i_flag drops -> request kind 3; i_flag set mid-OFFER -> req_valid held until ack.
REQ-036 vblank rising edge coincides with ack of an NMI offer -> NMI latch remains 1, second NMI offered after GAP.
REQ-037 rst asserted mid-OFFER with vblank high -> req_valid 0 next cycle, pending 0, no request after release.
